// File: rtl/truth_table_sweep.sv
// truth_table_sweep
//
// Sweeps a 3-input combinational logic stage through all eight input rows.
// For each row it holds the inputs for a settle time, samples the response
// and builds a captured truth table. It then compares that table against a
// golden table that was latched at start.
//
// Ports
//   clk_i        rising-edge clock for all state
//   rst_i        synchronous active-high reset
//   start_i      request a sweep (accepted only in IDLE)
//   abort_i      cancel an in-progress sweep
//   expected_i   golden truth table, bit 7 = row 000, bit 0 = row 111
//   in1_o..in3_o drive the stage under test, in1 = row bit 2, in3 = row bit 0
//   out_i        response of the stage under test
//   busy_o       high while a sweep is in progress
//   done_o       one-cycle pulse when a sweep completes
//   table_o      captured truth table, same bit order as expected_i
//   pass_o       captured table equals latched golden table (valid from done)
//
// Configuration macro
//   TRUTH_TABLE_SWEEP_SYNC_EN  when defined, out_i passes through a two-flop
//                              synchronizer before capture. Each settle
//                              phase then lasts two extra cycles to cover
//                              the synchronizer delay.

module truth_table_sweep #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [7:0] expected_i,
    output logic       in1_o,
    output logic       in2_o,
    output logic       in3_o,
    input  logic       out_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] table_o,
    output logic       pass_o
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        FINISH
    } state_e;

    // Nine bits so that 255 settle cycles plus the synchronizer allowance fit.
`ifdef TRUTH_TABLE_SWEEP_SYNC_EN
    localparam logic [8:0] CNT_LOAD = 9'(SETTLE_CYCLES + 2);
`else
    localparam logic [8:0] CNT_LOAD = 9'(SETTLE_CYCLES);
`endif

    state_e     state_q, state_d;
    logic [2:0] row_q, row_d;
    logic [8:0] settleCnt_q, settleCnt_d;
    logic [7:0] table_q, table_d;
    logic       pass_q, pass_d;
    logic [7:0] expLatched_q, expLatched_d;
    logic       sampleBit;

`ifdef TRUTH_TABLE_SWEEP_SYNC_EN
    logic syncA_q, syncB_q;

    // Two-flop synchronizer on the response; both stages clear on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            syncA_q <= 1'b0;
            syncB_q <= 1'b0;
        end else begin
            syncA_q <= out_i;
            syncB_q <= syncA_q;
        end
    end

    assign sampleBit = syncB_q;
`else
    assign sampleBit = out_i;
`endif

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            row_q        <= 3'd0;
            settleCnt_q  <= 9'd0;
            table_q      <= 8'h00;
            pass_q       <= 1'b0;
            expLatched_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            settleCnt_q  <= settleCnt_d;
            table_q      <= table_d;
            pass_q       <= pass_d;
            expLatched_q <= expLatched_d;
        end
    end

    // Next-state logic. Abort is checked before any table write so that a
    // cancelled sample never lands. In IDLE, abort also blocks start.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        settleCnt_d  = settleCnt_q;
        table_d      = table_q;
        pass_d       = pass_q;
        expLatched_d = expLatched_q;

        case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    expLatched_d = expected_i;
                    row_d        = 3'd0;
                    table_d      = 8'h00;
                    pass_d       = 1'b0;
                    settleCnt_d  = CNT_LOAD;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    settleCnt_d = settleCnt_q - 9'd1;
                    if (settleCnt_q == 9'd1) begin
                        state_d = SAMPLE;
                    end
                end
            end
            SAMPLE: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    table_d[3'd7 - row_q] = sampleBit;
                    if (row_q == 3'd7) begin
                        // Compare using the table that includes this last sample.
                        pass_d  = (table_d == expLatched_q);
                        state_d = FINISH;
                    end else begin
                        row_d       = row_q + 3'd1;
                        settleCnt_d = CNT_LOAD;
                        state_d     = SETTLE;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The stage inputs are driven only while a row is active.
    always_comb begin
        busy_o = (state_q == SETTLE) || (state_q == SAMPLE);
        done_o = (state_q == FINISH);
        {in1_o, in2_o, in3_o} = busy_o ? row_q : 3'b000;
    end

    assign table_o = table_q;
    assign pass_o  = pass_q;

endmodule
